wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset.
REQ-002 Parameter DEPTH, default 4, SHALL set the ALU-result queue depth (power of two, 2..16).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 alu_valid  input  1  ALU result presented.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result value.
REQ-008 alu_ready  output  1  queue can accept an ALU result this cycle.
REQ-009 ld_valid  input  1  load result presented; always accepted, no back-pressure.
REQ-010 ld_rd  input  5  load destination register.
REQ-011 ld_data  input  32  load result value.
REQ-012 wr_en  output  1  register-file write enable, registered.
REQ-013 wr_reg  output  5  register-file write index, registered.
REQ-014 wr_data  output  32  register-file write data, registered.
REQ-015 busy  output  1  high when count != 0.

Function
REQ-016 An ALU transfer SHALL occur when alu_valid && alu_ready at a rising edge.
REQ-017 alu_ready SHALL be (count < DEPTH), decoded from registered count only, with no combinational dependence on ld_valid or on a same-cycle pop.
REQ-018 Each edge, the next write SHALL be selected in this priority: (1) ld_valid; (2) queue head if count > 0; (3) the accepted ALU transfer if count == 0; (4) none, wr_en = 0.
REQ-019 Selected source SHALL appear on wr_en/wr_reg/wr_data one cycle after the edge: latency 1 for loads and for ALU results that bypass an empty queue.
REQ-020 An accepted ALU transfer not selected in the same cycle SHALL be pushed at the queue tail.
REQ-021 ALU results SHALL leave in acceptance order; ordering between load and ALU sources is not maintained, and upstream guarantees no same-rd conflict in flight.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-023 When full (count == DEPTH), alu_ready SHALL be 0 even if a pop occurs that cycle; the freed slot becomes available the next cycle.
REQ-024 While ld_valid is held high, the queue SHALL not drain; loads can starve ALU results indefinitely.
REQ-025 With no selection, wr_en SHALL be 0 and wr_reg/wr_data SHALL hold their previous values.

Reset
REQ-026 Asserting rst SHALL immediately force wr_en = 0, wr_reg = 0, wr_data = 0, count = 0, both pointers = 0, and busy = 0, so alu_ready = 1.
REQ-027 Reset mid-operation SHALL discard all queued entries, and no write from before reset SHALL appear afterwards.
REQ-028 The first write SHALL be possible at the first rising edge after rst deasserts.

Configuration
REQ-029 Macro WB_ARBITER_X0_DROP_EN, when defined, SHALL make the block discard any load or ALU result with rd == 0 at selection or enqueue: wr_en is never asserted with wr_reg == 0, x0 ALU transfers are accepted but not queued, and an x0 load does not block the queue head that cycle.
REQ-030 Without WB_ARBITER_X0_DROP_EN, rd == 0 results SHALL be treated like any other register, and the register file ignores them.

Verification
REQ-031 Single ALU: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF, queue empty -> next cycle wr_en=1, wr_reg=5, wr_data=0xDEADBEEF; busy stays 0.
REQ-032 Collision: ld (rd=7, 0x11111111) and ALU (rd=9, 0x22222222) in the same cycle -> cycle+1 writes x7, cycle+2 writes x9; busy is 1 for one cycle.
REQ-033 Fill and stall: ld_valid held 6 cycles while ALU offers rd=1..6 -> alu_ready drops after 4 accepts (DEPTH=4); after ld_valid drops, x1..x4 are written in order, then x5, x6.
REQ-034 Full with pop: count=4, ld_valid=0, alu_valid=1 -> alu_ready=0 that cycle, count=3 next cycle, alu_ready=1.
REQ-035 Reset mid-drain: count=3, assert rst -> wr_en=0 at once; after release no queued value is ever written.
REQ-036 x0 handling: ALU rd=0, data 0xFFFFFFFF -> with WB_ARBITER_X0_DROP_EN, wr_en stays 0; without it, wr_en=1 and wr_reg=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: loads win the register-file port, ALU results queue behind them in order.
// Optional build macro WB_ARBITER_X0_DROP_EN discards results addressed to x0.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        wr_en,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {SEL_NONE, SEL_LD, SEL_HEAD, SEL_BYP} sel_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t       mem_q [DEPTH];
  wb_ent_t       head;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    wr_reg_q, wr_reg_d;
  logic [31:0]   wr_data_q, wr_data_d;
  sel_e          sel;
  logic          alu_fire, alu_keep, ld_take, push, pop;

  // Ready depends on registered occupancy only, so a full queue stays closed even while popping.
  assign alu_ready = (count_q < CW'(DEPTH));
  assign alu_fire  = alu_valid && alu_ready;
  assign head      = mem_q[rd_ptr_q];

`ifdef WB_ARBITER_X0_DROP_EN
  assign ld_take  = ld_valid && (ld_rd != 5'd0);
  assign alu_keep = alu_fire && (alu_rd != 5'd0);
`else
  assign ld_take  = ld_valid;
  assign alu_keep = alu_fire;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel       = SEL_NONE;
    wr_en_d   = 1'b1;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;

    if (ld_take)                sel = SEL_LD;
    else if (count_q != '0)     sel = SEL_HEAD;
    else if (alu_keep)          sel = SEL_BYP;

    unique case (sel)
      SEL_LD:   begin wr_reg_d = ld_rd;   wr_data_d = ld_data;   end
      SEL_HEAD: begin wr_reg_d = head.rd; wr_data_d = head.data; end
      SEL_BYP:  begin wr_reg_d = alu_rd;  wr_data_d = alu_data;  end
      SEL_NONE: wr_en_d = 1'b0;
    endcase

    pop      = (sel == SEL_HEAD);
    push     = alu_keep && (sel != SEL_BYP);
    count_d  = count_q + CW'(push) - CW'(pop);
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
  end

  // NOTE: queue storage has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: alu_rd, data: alu_data};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
  assign busy    = (count_q != '0);

endmodule
